// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive framer.
//   state_t   : framer states
//   ERR_*     : err_code values
//   *_DEFAULT : default parameter values for the top level
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0]  SOF_DEFAULT           = 8'hA5;
    localparam int unsigned MAX_LEN_DEFAULT       = 16;
    localparam int unsigned TIMEOUT_TICKS_DEFAULT = 640;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Downstream payload stream (valid/ready).
//   m_data  : payload byte
//   m_valid : m_data valid
//   m_last  : final payload byte of the frame
//   m_ready : consumer accepts when m_valid & m_ready
interface uart_rx_frame_ctrl_if;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port
module uart_rx_frame_ctrl_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage is intentionally not reset; only a verified frame is ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART receiver byte stream (SOF, LEN, payload, CHK) and releases the
// payload over valid/ready only after the checksum verifies.
//   clk, reset_n  : clock, async active-low reset
//   s_tick        : 16x baud tick (inter-byte gap timing)
//   rx_dout/rx_done : received byte and its one-cycle strobe
//   stream        : payload output (master modport)
//   err_pulse     : one-cycle error strobe
//   err_code      : last error cause, held until the next err_pulse
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN       = MAX_LEN_DEFAULT,
    parameter logic [7:0]  SOF           = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_tick,
    input  logic [7:0]                  rx_dout,
    input  logic                        rx_done,
    uart_rx_frame_ctrl_if.master        stream,
    output logic                        err_pulse,
    output logic [1:0]                  err_code
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned GW = $clog2(TIMEOUT_TICKS + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    acc_q, acc_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          mv_q, mv_d;
    logic          ml_q, ml_d;
    logic [7:0]    md_q, md_d;
    logic          ep_q, ep_d;
    logic [1:0]    ec_q, ec_d;

    logic          buf_we;
    logic [AW-1:0] rd_sel;
    logic [7:0]    buf_rdata;
    logic [7:0]    sum;
    logic [LW-1:0] last_idx;
    logic          rd_is_last;
    logic          xfer;
    logic          timed;
    logic          timeout_hit;

    assign sum         = acc_q + rx_dout;
    assign last_idx    = len_q - LW'(1);
    assign rd_is_last  = (LW'(rd_q) == last_idx);
    assign xfer        = mv_q & stream.m_ready;
    assign timed       = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // A byte arriving on the threshold tick takes priority over the timeout.
    assign timeout_hit = timed && !rx_done && s_tick && (gap_q == GW'(TIMEOUT_TICKS - 1));

    // Read address looks one entry ahead on a handshake so m_data is ready next cycle.
    assign rd_sel = (state_q == ST_DRAIN && xfer && !rd_is_last) ? rd_q + AW'(1) : rd_q;

    uart_rx_frame_ctrl_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_frame_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_q),
        .wdata (rx_dout),
        .raddr (rd_sel),
        .rdata (buf_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            len_q   <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            gap_q   <= '0;
            mv_q    <= 1'b0;
            ml_q    <= 1'b0;
            md_q    <= '0;
            ep_q    <= 1'b0;
            ec_q    <= ERR_LEN;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            mv_q    <= mv_d;
            ml_q    <= ml_d;
            md_q    <= md_d;
            ep_q    <= ep_d;
            ec_q    <= ec_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        mv_d    = mv_q;
        ml_d    = ml_q;
        md_d    = md_q;
        ep_d    = 1'b0;
        ec_d    = ec_q;
        buf_we  = 1'b0;

        // Gap counter only runs between bytes of a frame in progress.
        if (!timed || rx_done) begin
            gap_d = '0;
        end else if (s_tick) begin
            gap_d = gap_q + GW'(1);
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (rx_done && rx_dout == SOF) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_done) begin
                    if (rx_dout != 8'd0 && rx_dout <= 8'(MAX_LEN)) begin
                        len_d   = LW'(rx_dout);
                        acc_d   = rx_dout;
                        wr_d    = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        ep_d    = 1'b1;
                        ec_d    = ERR_LEN;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    buf_we = 1'b1;
                    acc_d  = sum;
                    wr_d   = wr_q + AW'(1);
                    if (LW'(wr_q) == last_idx) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_done) begin
                    if (sum == 8'd0) begin
                        rd_d    = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        ep_d    = 1'b1;
                        ec_d    = ERR_CHK;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes arriving now are dropped; the drain itself is unaffected.
                if (rx_done) begin
                    ep_d = 1'b1;
                    ec_d = ERR_OVERRUN;
                end
                if (!mv_q) begin
                    mv_d = 1'b1;
                    md_d = buf_rdata;
                    ml_d = rd_is_last;
                end else if (xfer) begin
                    if (rd_is_last) begin
                        mv_d    = 1'b0;
                        ml_d    = 1'b0;
                        state_d = ST_HUNT;
                    end else begin
                        rd_d = rd_sel;
                        md_d = buf_rdata;
                        ml_d = (LW'(rd_sel) == last_idx);
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (timeout_hit) begin
            ep_d    = 1'b1;
            ec_d    = ERR_TIMEOUT;
            state_d = ST_HUNT;
        end
    end

    assign stream.m_data  = md_q;
    assign stream.m_valid = mv_q;
    assign stream.m_last  = ml_q;
    assign err_pulse      = ep_q;
    assign err_code       = ec_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frame table, multi-cycle
// corner sequences, and randomized frames checked against a frame-level model.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       err_pulse;
    logic [1:0] err_code;
    bit         rand_mode = 1'b0;

    int nchk = 0;
    int nfail = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [1:0] gerr_q[$];
    logic [1:0] experr_q[$];

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tick    (s_tick),
        .rx_dout   (rx_dout),
        .rx_done   (rx_done),
        .stream    (bus),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: collects handshakes and errors, checks stall stability and pulse width.
    logic       hold_p = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;
    logic       prev_err = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_p   <= 1'b0;
            prev_err <= 1'b0;
        end else begin
            if (hold_p) begin
                check("stall_valid", 32'(bus.m_valid), 32'd1);
                check("stall_data", 32'(bus.m_data), 32'(hold_d));
                check("stall_last", 32'(bus.m_last), 32'(hold_l));
            end
            if (err_pulse) begin
                check("err_one_cycle", 32'(prev_err), 32'd0);
                gerr_q.push_back(err_code);
            end
            if (bus.m_valid && bus.m_ready) got_q.push_back({bus.m_last, bus.m_data});
            hold_p   <= bus.m_valid && !bus.m_ready;
            hold_d   <= bus.m_data;
            hold_l   <= bus.m_last;
            prev_err <= err_pulse;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            bus.m_ready = 1'($urandom % 2);
            s_tick      = 1'($urandom % 2);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_dout = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
    endtask

    task automatic tick();
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check($sformatf("%s_beat_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_err_count", tag), 32'(gerr_q.size()), 32'(experr_q.size()));
        n = (gerr_q.size() < experr_q.size()) ? gerr_q.size() : experr_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_err%0d", tag, i), 32'(gerr_q[i]), 32'(experr_q[i]));
        got_q.delete();
        exp_q.delete();
        gerr_q.delete();
        experr_q.delete();
    endtask

    // Frame-level reference: first SOF, then LEN rule, then sum rule.
    task automatic model(input logic [7:0] s[$]);
        int i = 0;
        int len;
        int total;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 1 >= s.size()) return;
        len = int'(s[i+1]);
        if (len == 0 || len > 16) begin
            experr_q.push_back(2'd0);
            return;
        end
        total = len;
        for (int k = 0; k <= len; k++) total += int'(s[i+2+k]);
        if (total % 256 == 0) begin
            for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), s[i+2+k]});
        end else begin
            experr_q.push_back(2'd1);
        end
    endtask

    typedef struct {
        logic [159:0] bytes;
        int           nb;
        logic [127:0] pay;
        int           np;
        int           nerr;
        logic [1:0]   ec;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        bus.m_ready = 1'b1;
        for (int j = 0; j < v.nb; j++) send(v.bytes[(v.nb - 1 - j) * 8 +: 8]);
        cycles(24);
        for (int j = 0; j < v.np; j++) exp_q.push_back({(j == v.np - 1), v.pay[(v.np - 1 - j) * 8 +: 8]});
        if (v.nerr > 0) begin
            experr_q.push_back(v.ec);
            check($sformatf("vec%0d_err_code_held", idx), 32'(err_code), 32'(v.ec));
        end
        compare_queues($sformatf("vec%0d", idx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       sv_v[7];
        logic [7:0] sv_d[7];
        logic       sv_l[7];
        logic [7:0] fr[$];
        int         len, sum, kind, bound;
        logic [7:0] b;

        vecs[0] = '{48'hA5_03_11_22_33_97, 6, 128'h112233, 3, 0, 2'd0};
        vecs[1] = '{48'hA5_03_11_22_33_98, 6, 128'h0, 0, 1, 2'd1};
        vecs[2] = vecs[0];
        vecs[3] = '{32'hA5_00_11_22, 4, 128'h0, 0, 1, 2'd0};
        vecs[4] = '{40'hA5_11_11_22_33, 5, 128'h0, 0, 1, 2'd0};
        vecs[5] = '{48'h5A_00_A5_01_FF_00, 6, 128'hFF, 1, 0, 2'd0};
        vecs[6] = '{{8'hA5, 8'h10, 128'h0102030405060708090A0B0C0D0E0F10, 8'h68}, 19,
                    128'h0102030405060708090A0B0C0D0E0F10, 16, 0, 2'd0};
        vecs[7] = '{40'hA5_02_FF_FF_00, 5, 128'hFFFF, 2, 0, 2'd0};

        bus.m_ready = 1'b0;
        @(negedge clk);
        check("reset_m_valid", 32'(bus.m_valid), 32'd0);
        check("reset_m_last", 32'(bus.m_last), 32'd0);
        check("reset_err_pulse", 32'(err_pulse), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        step();
        reset_n = 1'b1;
        cycles(2);

        for (int i = 0; i < 8; i++) run_vec(i);

        // First m_valid two clocks after the CHK strobe, then one byte per cycle.
        bus.m_ready = 1'b1;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        rx_dout = 8'h97;
        rx_done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            sv_v[k] = bus.m_valid;
            sv_d[k] = bus.m_data;
            sv_l[k] = bus.m_last;
            @(posedge clk);
            #1;
            rx_done = 1'b0;
        end
        check("lat_v0", 32'(sv_v[0]), 32'd0);
        check("lat_v1", 32'(sv_v[1]), 32'd0);
        check("lat_v2", 32'(sv_v[2]), 32'd1);
        check("lat_d2", 32'(sv_d[2]), 32'h11);
        check("lat_l2", 32'(sv_l[2]), 32'd0);
        check("lat_d3", 32'(sv_d[3]), 32'h22);
        check("lat_l3", 32'(sv_l[3]), 32'd0);
        check("lat_v4", 32'(sv_v[4]), 32'd1);
        check("lat_d4", 32'(sv_d[4]), 32'h33);
        check("lat_l4", 32'(sv_l[4]), 32'd1);
        check("lat_v5", 32'(sv_v[5]), 32'd0);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        compare_queues("latency");

        // Timeout fires exactly on the 640th idle tick.
        send(8'hA5); send(8'h02); send(8'h11);
        repeat (639) tick();
        @(negedge clk);
        check("to_before_640", 32'(err_pulse), 32'd0);
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        @(negedge clk);
        check("to_at_640_pulse", 32'(err_pulse), 32'd1);
        check("to_at_640_code", 32'(err_code), 32'd2);
        step();
        experr_q.push_back(2'd2);
        compare_queues("timeout");

        // A byte on the threshold tick wins.
        send(8'hA5); send(8'h02); send(8'h11);
        repeat (639) tick();
        s_tick = 1'b1;
        rx_dout = 8'h22;
        rx_done = 1'b1;
        step();
        s_tick = 1'b0;
        rx_done = 1'b0;
        step();
        send(8'hCB);
        cycles(8);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        compare_queues("to_byte_wins");

        // Overrun during a stalled drain.
        bus.m_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h86);
        cycles(5);
        check("ovr_valid_pre", 32'(bus.m_valid), 32'd1);
        rx_dout = 8'h5A;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        cycles(44);
        @(negedge clk);
        check("ovr_valid", 32'(bus.m_valid), 32'd1);
        check("ovr_data", 32'(bus.m_data), 32'hAB);
        check("ovr_last", 32'(bus.m_last), 32'd0);
        check("ovr_code", 32'(err_code), 32'd3);
        bus.m_ready = 1'b1;
        cycles(6);
        exp_q.push_back({1'b0, 8'hAB});
        exp_q.push_back({1'b1, 8'hCD});
        experr_q.push_back(2'd3);
        compare_queues("overrun");

        // Reset mid-payload.
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_pay_valid", 32'(bus.m_valid), 32'd0);
        check("rst_pay_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_pay_err_code", 32'(err_code), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Reset mid-drain, after a checksum error has set err_code.
        send(8'hA5); send(8'h01); send(8'h10); send(8'h00);
        bus.m_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h10); send(8'hEF);
        cycles(4);
        check("rst_drn_pre_valid", 32'(bus.m_valid), 32'd1);
        check("rst_drn_pre_code", 32'(err_code), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_drn_valid", 32'(bus.m_valid), 32'd0);
        check("rst_drn_last", 32'(bus.m_last), 32'd0);
        check("rst_drn_err_code", 32'(err_code), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        experr_q.push_back(2'd1);
        compare_queues("reset");
        run_vec(0);

        // Randomized frames with random ready and ticks.
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            repeat ($urandom % 3) begin
                b = 8'($urandom);
                fr.push_back((b == 8'hA5) ? 8'h00 : b);
            end
            fr.push_back(8'hA5);
            kind = int'($urandom % 4);
            if (kind == 3) begin
                len = ($urandom % 2 == 0) ? 0 : 17 + int'($urandom % 239);
                fr.push_back(8'(len));
                repeat ($urandom % 3) begin
                    b = 8'($urandom);
                    fr.push_back((b == 8'hA5) ? 8'h3C : b);
                end
            end else begin
                len = 1 + int'($urandom % 16);
                fr.push_back(8'(len));
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    sum += int'(b);
                    fr.push_back(b);
                end
                b = 8'(256 - (sum % 256));
                if (kind == 2) b = b + 8'(1 + $urandom % 255);
                fr.push_back(b);
            end
            model(fr);
            foreach (fr[k]) begin
                send(fr[k]);
                cycles(int'($urandom % 3));
            end
            cycles(3);
            bound = 0;
            while (bus.m_valid && bound < 500) begin
                step();
                bound++;
            end
            if (bound >= 500) check("rand_drain_bound", 32'd1, 32'd0);
        end
        rand_mode = 1'b0;
        bus.m_ready = 1'b1;
        s_tick = 1'b0;
        cycles(4);
        compare_queues("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
